// File: rtl/iic_slave_mem_if.sv
// Bus bundle between the I2C master side and iic_slave_mem.
// sda is not part of the bundle: it is the resolved open-drain net and stays a plain inout on the slave.
interface iic_slave_mem_if;
   logic       scl;
   logic       wr_done;
   logic [7:0] wr_data;
   logic       busy;

   modport master (output scl, input wr_done, input wr_data, input busy);
   modport slave  (input scl, output wr_done, output wr_data, output busy);
endinterface

// File: rtl/iic_slave_mem.sv
// 24C02-style I2C slave with a 2**MEM_AW byte register memory.
// SCL/SDA are oversampled in the s_clk domain; the slave only ever pulls sda low or releases it.
module iic_slave_mem #(
   parameter logic [6:0] DEV_ADDR = 7'h50,
   parameter int         MEM_AW   = 8,
   parameter int         SYNC_STG = 2
) (
   input  logic           s_clk,
   input  logic           s_rst_n,
   iic_slave_mem_if.slave bus,
   inout  wire            sda
);

   typedef enum logic [3:0] {
      IDLE, DEV, ACK_DEV, WADDR, ACK_WADDR, WR_DATA, ACK_WR, RD_DATA, RD_ACK, WAIT_STOP
   } state_t;

   state_t              state, state_nx;
   logic [SYNC_STG-1:0] scl_sync, sda_sync;
   logic                scl_s, sda_s, scl_d, sda_d;
   logic                scl_rise, scl_fall, start_det, stop_det;
   logic [7:0]          shift, shift_nx;
   logic [3:0]          bit_cnt, bit_cnt_nx;
   logic [MEM_AW-1:0]   ptr, ptr_nx;
   logic                rw, rw_nx, mst_ack, mst_ack_nx;
   logic                sda_oe, sda_oe_nx;
   logic                wr_done, wr_done_nx, mem_we;
   logic [7:0]          wr_data, wr_data_nx;
   logic [7:0]          mem [2**MEM_AW];
   logic [7:0]          mem_rd;

   // Lines idle high, so the synchronizers reset to 1 to avoid a fake edge after reset.
   always_ff @(posedge s_clk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_d    <= 1'b1;
         sda_d    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STG-2:0], bus.scl};
         sda_sync <= {sda_sync[SYNC_STG-2:0], sda};
         scl_d    <= scl_s;
         sda_d    <= sda_s;
      end
   end

   assign scl_s     = scl_sync[SYNC_STG-1];
   assign sda_s     = sda_sync[SYNC_STG-1];
   assign scl_rise  = scl_s & ~scl_d;
   assign scl_fall  = ~scl_s & scl_d;
   assign start_det = scl_s & scl_d & sda_d & ~sda_s;
   assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
   assign mem_rd    = mem[ptr];

   always_ff @(posedge s_clk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         state   <= IDLE;
         shift   <= 8'h00;
         bit_cnt <= 4'd0;
         ptr     <= '0;
         rw      <= 1'b0;
         mst_ack <= 1'b0;
         sda_oe  <= 1'b0;
         wr_done <= 1'b0;
         wr_data <= 8'h00;
      end else begin
         state   <= state_nx;
         shift   <= shift_nx;
         bit_cnt <= bit_cnt_nx;
         ptr     <= ptr_nx;
         rw      <= rw_nx;
         mst_ack <= mst_ack_nx;
         sda_oe  <= sda_oe_nx;
         wr_done <= wr_done_nx;
         wr_data <= wr_data_nx;
      end
   end

   // Bits are taken on SCL rise; sda only changes on SCL fall, so our own drive never looks like START/STOP.
   always_comb begin
      state_nx   = state;
      shift_nx   = shift;
      bit_cnt_nx = bit_cnt;
      ptr_nx     = ptr;
      rw_nx      = rw;
      mst_ack_nx = mst_ack;
      sda_oe_nx  = sda_oe;
      wr_done_nx = 1'b0;
      wr_data_nx = wr_data;
      mem_we     = 1'b0;
      if (stop_det) begin
         state_nx  = IDLE;
         sda_oe_nx = 1'b0;
      end else if (start_det) begin
         state_nx   = DEV;
         bit_cnt_nx = 4'd0;
         sda_oe_nx  = 1'b0;
      end else begin
         case (state)
            DEV, WADDR, WR_DATA: begin
               if (scl_rise && bit_cnt != 4'd8) begin
                  shift_nx   = {shift[6:0], sda_s};
                  bit_cnt_nx = bit_cnt + 4'd1;
               end else if (scl_fall && bit_cnt == 4'd8) begin
                  bit_cnt_nx = 4'd0;
                  sda_oe_nx  = 1'b1;
                  if (state == DEV) begin
                     if (shift[7:1] == DEV_ADDR) begin
                        state_nx = ACK_DEV;
                        rw_nx    = shift[0];
                     end else begin
                        state_nx  = IDLE;
                        sda_oe_nx = 1'b0;
                     end
                  end else if (state == WADDR) begin
                     state_nx = ACK_WADDR;
                     ptr_nx   = MEM_AW'(shift);
                  end else begin
                     state_nx = ACK_WR;
                  end
               end
            end
            ACK_DEV: begin
               if (scl_fall) begin
                  bit_cnt_nx = 4'd0;
                  if (rw) begin
                     state_nx  = RD_DATA;
                     shift_nx  = mem_rd;
                     sda_oe_nx = ~mem_rd[7];
                  end else begin
                     state_nx  = WADDR;
                     sda_oe_nx = 1'b0;
                  end
               end
            end
            ACK_WADDR: begin
               if (scl_fall) begin
                  state_nx  = WR_DATA;
                  sda_oe_nx = 1'b0;
               end
            end
            ACK_WR: begin
               if (scl_fall) begin
                  mem_we     = 1'b1;
                  wr_done_nx = 1'b1;
                  wr_data_nx = shift;
                  ptr_nx     = ptr + 1'b1;
                  state_nx   = WR_DATA;
                  sda_oe_nx  = 1'b0;
               end
            end
            RD_DATA: begin
               if (scl_fall) begin
                  if (bit_cnt == 4'd7) begin
                     state_nx  = RD_ACK;
                     sda_oe_nx = 1'b0;
                  end else begin
                     bit_cnt_nx = bit_cnt + 4'd1;
                     shift_nx   = {shift[6:0], 1'b0};
                     sda_oe_nx  = ~shift[6];
                  end
               end
            end
            RD_ACK: begin
               if (scl_rise) begin
                  mst_ack_nx = ~sda_s;
                  if (!sda_s)
                     ptr_nx = ptr + 1'b1;
               end else if (scl_fall) begin
                  if (mst_ack) begin
                     state_nx   = RD_DATA;
                     bit_cnt_nx = 4'd0;
                     shift_nx   = mem_rd;
                     sda_oe_nx  = ~mem_rd[7];
                  end else begin
                     state_nx = WAIT_STOP;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge s_clk) begin
      if (mem_we)
         mem[ptr] <= shift;
   end

   assign sda         = sda_oe ? 1'b0 : 1'bz;
   assign bus.wr_done = wr_done;
   assign bus.wr_data = wr_data;
   assign bus.busy    = (state != IDLE);

endmodule

// File: tb/tb_iic_slave_mem.sv
// Self-checking bench for iic_slave_mem: table-driven byte writes, protocol corner cases,
// and randomized write/read traffic checked against a plain array model of the memory.
module tb_iic_slave_mem;

   localparam int Q = 5;

   typedef struct {
      logic [7:0] dev;
      logic [7:0] addr;
      logic [7:0] data;
      logic       exp_ack;
      int         exp_wr_done;
      logic [7:0] exp_wr_data;
   } vec_t;

   logic s_clk = 1'b0;
   logic s_rst_n;
   logic m_low;
   wire  sda;

   iic_slave_mem_if bus ();

   assign sda = m_low ? 1'b0 : 1'bz;
   pullup (sda);

   iic_slave_mem #(.DEV_ADDR(7'h50), .MEM_AW(8), .SYNC_STG(2)) dut (
      .s_clk  (s_clk),
      .s_rst_n(s_rst_n),
      .bus    (bus),
      .sda    (sda)
   );

   always #10 s_clk = ~s_clk;

   int n_cmp = 0;
   int n_bad = 0;
   int wd_count = 0;

   always @(negedge s_clk)
      if (bus.wr_done === 1'b1) wd_count++;

   logic [7:0] ref_mem   [256];
   bit         ref_valid [256];
   int         ref_ptr;
   logic [7:0] wbuf [4];
   int         waddrs [$];
   vec_t       vecs [6];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic qwait();
      repeat (Q) @(negedge s_clk);
   endtask

   function automatic logic sda_level();
      return (sda !== 1'b0);
   endfunction

   task automatic i2c_start();
      m_low = 1'b0; qwait();
      bus.scl = 1'b1; qwait();
      m_low = 1'b1; qwait();
      bus.scl = 1'b0; qwait();
   endtask

   task automatic i2c_stop();
      m_low = 1'b1; qwait();
      bus.scl = 1'b1; qwait();
      m_low = 1'b0; qwait(); qwait();
   endtask

   task automatic write_bit(input logic b);
      m_low = ~b; qwait();
      bus.scl = 1'b1; qwait(); qwait();
      bus.scl = 1'b0; qwait();
   endtask

   task automatic read_bit(output logic b);
      m_low = 1'b0; qwait();
      bus.scl = 1'b1; qwait();
      b = sda_level(); qwait();
      bus.scl = 1'b0; qwait();
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      logic b;
      for (int i = 7; i >= 0; i--) write_bit(d[i]);
      read_bit(b);
      ack = ~b;
   endtask

   task automatic read_byte(input logic give_ack, output logic [7:0] d);
      logic b;
      d = 8'h00;
      for (int i = 0; i < 8; i++) begin
         read_bit(b);
         d = {d[6:0], b};
      end
      if (give_ack) write_bit(1'b0);
      else begin
         read_bit(b);
         checkOutput("nack bit released", b, 1'b1);
      end
   endtask

   task automatic model_write(input logic [7:0] addr, input int n);
      ref_ptr = addr;
      for (int i = 0; i < n; i++) begin
         ref_mem[ref_ptr]   = wbuf[i];
         ref_valid[ref_ptr] = 1'b1;
         ref_ptr = (ref_ptr + 1) % 256;
      end
   endtask

   // Full single-byte write transaction from one table row.
   task automatic applyStimulus(input vec_t v, input int idx);
      logic a0, a1, a2, busy_mid;
      int   wd0;
      wd0 = wd_count;
      i2c_start();
      write_byte(v.dev, a0);
      write_byte(v.addr, a1);
      write_byte(v.data, a2);
      busy_mid = bus.busy;
      i2c_stop();
      checkOutput($sformatf("vec%0d dev ack", idx), a0, v.exp_ack);
      checkOutput($sformatf("vec%0d addr ack", idx), a1, v.exp_ack);
      checkOutput($sformatf("vec%0d data ack", idx), a2, v.exp_ack);
      checkOutput($sformatf("vec%0d busy mid", idx), busy_mid, v.exp_ack);
      checkOutput($sformatf("vec%0d busy after stop", idx), bus.busy, 1'b0);
      checkOutput($sformatf("vec%0d wr_done pulses", idx), wd_count - wd0, v.exp_wr_done);
      checkOutput($sformatf("vec%0d wr_data", idx), bus.wr_data, v.exp_wr_data);
      if (v.exp_ack) begin
         wbuf[0] = v.data;
         model_write(v.addr, 1);
      end
   endtask

   task automatic write_seq(input logic [7:0] addr, input int n, input string tag);
      logic a;
      int   wd0;
      wd0 = wd_count;
      i2c_start();
      write_byte(8'hA0, a); checkOutput({tag, " dev ack"}, a, 1'b1);
      write_byte(addr, a);  checkOutput({tag, " addr ack"}, a, 1'b1);
      for (int i = 0; i < n; i++) begin
         write_byte(wbuf[i], a);
         checkOutput($sformatf("%s data%0d ack", tag, i), a, 1'b1);
      end
      checkOutput({tag, " busy mid"}, bus.busy, 1'b1);
      i2c_stop();
      checkOutput({tag, " busy after stop"}, bus.busy, 1'b0);
      checkOutput({tag, " wr_done pulses"}, wd_count - wd0, n);
      checkOutput({tag, " wr_data"}, bus.wr_data, wbuf[n-1]);
      model_write(addr, n);
   endtask

   task automatic read_seq(input logic [7:0] addr, input int n, input string tag);
      logic       a;
      logic [7:0] d;
      i2c_start();
      write_byte(8'hA0, a); checkOutput({tag, " dev ack"}, a, 1'b1);
      write_byte(addr, a);  checkOutput({tag, " addr ack"}, a, 1'b1);
      i2c_start();
      write_byte(8'hA1, a); checkOutput({tag, " rd dev ack"}, a, 1'b1);
      ref_ptr = addr;
      for (int i = 0; i < n; i++) begin
         read_byte(i != n - 1, d);
         if (ref_valid[ref_ptr])
            checkOutput($sformatf("%s byte%0d @%02h", tag, i, ref_ptr), d, ref_mem[ref_ptr]);
         ref_ptr = (ref_ptr + 1) % 256;
      end
      i2c_stop();
   endtask

   initial begin
      logic       a, b;
      logic [7:0] d;
      int         wd0;

      vecs[0] = '{8'hA0, 8'h10, 8'h5A, 1'b1, 1, 8'h5A};
      vecs[1] = '{8'hA0, 8'h00, 8'hC3, 1'b1, 1, 8'hC3};
      vecs[2] = '{8'hA0, 8'h80, 8'h01, 1'b1, 1, 8'h01};
      vecs[3] = '{8'hA2, 8'h00, 8'h77, 1'b0, 0, 8'h01};
      vecs[4] = '{8'hA0, 8'h20, 8'h9C, 1'b1, 1, 8'h9C};
      vecs[5] = '{8'hA0, 8'h7F, 8'hFF, 1'b1, 1, 8'hFF};
      for (int i = 0; i < 256; i++) ref_valid[i] = 1'b0;
      ref_ptr = 0;

      bus.scl = 1'b1;
      m_low   = 1'b0;
      s_rst_n = 1'b0;
      repeat (5) @(negedge s_clk);
      checkOutput("reset busy", bus.busy, 1'b0);
      checkOutput("reset wr_done", bus.wr_done, 1'b0);
      checkOutput("reset wr_data", bus.wr_data, 8'h00);
      checkOutput("reset sda released", sda_level(), 1'b1);
      s_rst_n = 1'b1;
      repeat (5) @(negedge s_clk);

      $display("[TB] table-driven byte writes");
      for (int i = 0; i < 6; i++) applyStimulus(vecs[i], i);

      $display("[TB] random read of 0x10");
      read_seq(8'h10, 1, "rand read");

      $display("[TB] page write wrap and sequential read");
      wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
      write_seq(8'hFE, 3, "page wrap");
      read_seq(8'hFE, 3, "seq read");

      // STOP after four data bits: nothing committed, pointer stays at the word address.
      $display("[TB] stop abort mid-byte");
      wd0 = wd_count;
      i2c_start();
      write_byte(8'hA0, a);
      write_byte(8'h20, a);
      ref_ptr = 8'h20;
      write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
      i2c_stop();
      checkOutput("abort wr_done", wd_count - wd0, 0);
      i2c_start();
      write_byte(8'hA1, a);
      checkOutput("cur read dev ack", a, 1'b1);
      read_byte(1'b0, d);
      i2c_stop();
      checkOutput("cur read after abort", d, ref_mem[ref_ptr]);
      wbuf[0] = 8'h3C;
      write_seq(8'h21, 1, "post-stop write");
      read_seq(8'h20, 2, "post-stop read");

      $display("[TB] reset mid-read");
      i2c_start();
      write_byte(8'hA0, a);
      write_byte(8'h80, a);
      i2c_start();
      write_byte(8'hA1, a);
      for (int i = 0; i < 3; i++) read_bit(b);
      checkOutput("mid-read slave drive", sda_level(), ref_mem[8'h80][4]);
      s_rst_n = 1'b0;
      repeat (2) @(negedge s_clk);
      checkOutput("reset mid-read sda", sda_level(), 1'b1);
      checkOutput("reset mid-read busy", bus.busy, 1'b0);
      checkOutput("reset mid-read wr_data", bus.wr_data, 8'h00);
      s_rst_n = 1'b1;
      repeat (5) @(negedge s_clk);
      wbuf[0] = 8'hE7;
      write_seq(8'h41, 1, "post-reset write");
      read_seq(8'h41, 1, "post-reset read");

      $display("[TB] randomized traffic");
      for (int t = 0; t < 16; t++) begin
         if (waddrs.size() == 0 || $urandom_range(0, 1) == 1) begin
            logic [7:0] ad;
            int         n;
            ad = 8'($urandom_range(0, 255));
            n  = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
            write_seq(ad, n, $sformatf("rnd wr%0d", t));
            waddrs.push_back(int'(ad));
         end else begin
            int k;
            k = $urandom_range(0, waddrs.size() - 1);
            read_seq(8'(waddrs[k]), $urandom_range(1, 3), $sformatf("rnd rd%0d", t));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/iic_slave_mem.md
Name: iic_slave_mem

Overview:
- Synthesizable I2C slave with a 256-byte register memory, 24C02-style protocol.
- Sits directly downstream of the I2C master controller: consumes its `i_clk` (SCL) and the shared open-drain `sda` line.
- Serves as an on-chip target for board bring-up and as a self-checking partner in the master's bench.
- Oversamples SCL/SDA in the `s_clk` domain; no logic is clocked by SCL.

Parameters:
- DEV_ADDR, 7'h50, 7-bit device address the slave answers to (write byte 0xA0, read byte 0xA1).
- MEM_AW, 8, memory address width; depth = 2**MEM_AW.
- SYNC_STG, 2, synchronizer flops on `scl` and `sda` input.

Ports:
- s_clk  in  1  system clock, 50 MHz.
- s_rst_n  in  1  asynchronous active-low reset.
- scl  in  1  I2C clock from the master (`i_clk`).
- sda  inout  1  I2C data. The slave only ever drives 0 or Z. An external pull-up is modelled in the bench.
- wr_done  out  1  one-cycle pulse per data byte committed to memory.
- wr_data  out  8  last byte written; held until the next write.
- busy  out  1  high from START detection to STOP/abort.

Behaviour:
- Reset is asynchronous on `s_rst_n` low.
  - All state returns to IDLE; `sda` is released (Z).
  - `wr_done`=0, `wr_data`=8'h00, `busy`=0, address pointer = 0.
  - Memory contents are not reset.
- Input sampling: `scl` and `sda` pass through SYNC_STG flops, plus one history flop for edge detection.
  - Requirement: SCL high and low phases are each ≥ 4 `s_clk` cycles.
- Condition detection:
  - START = SDA falling while SCL high.
  - STOP = SDA rising while SCL high.
  - START and STOP are honoured in every state.
  - START in any state → DEV state, bit counter cleared (repeated start).
  - STOP in any state → IDLE, `sda` released, `busy`=0.
- Timing rules:
  - Data bits are sampled on synchronized SCL rising edges, MSB first.
  - The slave changes `sda` only on synchronized SCL falling edges, one `s_clk` after the edge is detected.
- States:
  - IDLE: wait for START.
  - DEV: shift 8 bits. On the 8th bit, if [7:1]==DEV_ADDR go to ACK_DEV, else go to IDLE without ACK (line stays Z).
  - ACK_DEV: drive 0 for one SCL period. Then R/W=0 → WADDR; R/W=1 → RD_DATA, loading the byte at the current pointer.
  - WADDR: shift 8 bits into the pointer, then ACK_WADDR (drive 0 for one SCL period), then WR_DATA.
  - WR_DATA: shift 8 bits, then ACK_WR. At the ACK SCL fall:
    - write mem[ptr];
    - pulse `wr_done`;
    - update `wr_data`;
    - ptr ← ptr+1, wrapping modulo 2**MEM_AW;
    - return to WR_DATA.
  - RD_DATA: drive bit 7..0 of mem[ptr] (0 → drive low, 1 → Z). After the 8th SCL fall, release and go to RD_ACK.
  - RD_ACK: sample the master ACK on SCL rise.
    - ACK=0: ptr+1 with wrap, load next byte, back to RD_DATA.
    - NACK=1: go to WAIT_STOP, line released.
- Random read sequence: write dev addr + word addr, then repeated START with the read byte. The pointer loaded in WADDR persists into the read phase.
- STOP mid-byte: the partial byte is discarded, no memory write, pointer unchanged.
- A write and its `wr_done` happen only after a full 8 bits plus the ACK clock.

Test Plan:
- Byte write: START, 0xA0, 0x10, 0x5A, STOP.
  - Required: ACK on all three bytes, `wr_done` pulses once, `wr_data`=0x5A, mem[0x10]=0x5A, `busy` falls after STOP.
- Random read: START, 0xA0, 0x10, Sr, 0xA1, read one byte, master NACK, STOP.
  - Required: byte on `sda` = 0x5A; slave releases `sda` for the NACK bit.
- Wrong address: START, 0xA2, 0x00.
  - Required: `sda` stays high (NACK) on the 9th clock, no `wr_done`, FSM returns to IDLE until the next START.
- Page write wrap: START, 0xA0, 0xFE, 0x11, 0x22, 0x33, STOP.
  - Required: mem[0xFE]=0x11, mem[0xFF]=0x22, mem[0x00]=0x33, three `wr_done` pulses.
- Sequential read: from address 0xFE read 3 bytes with ACK, ACK, NACK.
  - Required: 0x11, 0x22, 0x33 returned in order.
- Abort cases:
  - STOP after 4 data bits → no memory write, pointer unchanged.
  - `s_rst_n` low mid-read → `sda` released within the reset assertion, `busy`=0.
  - A following byte write succeeds normally after either abort.
